// File: rtl/mux_pkg.sv
// mux_pkg: shared width defaults, select-width helper and arbitration mode enum
package mux_pkg;
  localparam int DATA_W = 32;
  typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_e;
  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arb_mux_picker.sv
// rr_picker: combinational cyclic first-valid search from a start index, or forced single-channel grant
module rr_picker
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = sel_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] start,
  input  logic             force_en,
  input  logic [SEL_W-1:0] force_sel,
  output logic             gnt_valid,
  output logic [N-1:0]     gnt_oh,
  output logic [SEL_W-1:0] gnt_idx
);
  always_comb begin
    int j;
    j = 0;
    gnt_valid = 1'b0;
    gnt_idx = '0;
    if (force_en) begin
      for (int i = 0; i < N; i++)
        if (force_sel == SEL_W'(i) && req[i]) begin
          gnt_valid = 1'b1;
          gnt_idx = SEL_W'(i);
        end
    end else begin
      // walk offsets farthest-first so the nearest valid channel is written last
      for (int k = N - 1; k >= 0; k--) begin
        j = int'(start) + k;
        j = (j >= N) ? j - N : j;
        if (req[j]) begin
          gnt_valid = 1'b1;
          gnt_idx = SEL_W'(j);
        end
      end
    end
  end
  assign gnt_oh = gnt_valid ? N'(1) << gnt_idx : '0;
endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-input arbitrating registered mux; RR_ARB_MUX_FIXED_PRIO_EN selects fixed priority
module rr_arb_mux
  import mux_pkg::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = sel_w(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    force_en,
  input  logic [SEL_W-1:0]        force_sel,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);
  logic load, xfer, gnt_valid;
  logic [NUM_IN-1:0] gnt_oh;
  logic [SEL_W-1:0] gnt_idx, start;
  assign load = !out_valid || out_ready;
  assign xfer = rst_n && load && gnt_valid;
  assign in_ready = (rst_n && load) ? gnt_oh : '0;
`ifdef RR_ARB_MUX_FIXED_PRIO_EN
  localparam arb_mode_e ARB_MODE = ARB_FIXED;
  assign start = '0;
`else
  localparam arb_mode_e ARB_MODE = ARB_RR;
  logic [SEL_W-1:0] rr_ptr;
  // forced transfers bypass arbitration, so they must not disturb fairness
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_ptr <= '0;
    else if (xfer && !force_en) rr_ptr <= (gnt_idx == SEL_W'(NUM_IN - 1)) ? '0 : gnt_idx + 1'b1;
  assign start = rr_ptr;
`endif
  rr_picker #(.N(NUM_IN), .SEL_W(SEL_W)) u_pick (
    .req      (in_valid),
    .start    (start),
    .force_en (force_en),
    .force_sel(force_sel),
    .gnt_valid(gnt_valid),
    .gnt_oh   (gnt_oh),
    .gnt_idx  (gnt_idx)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data <= in_data[gnt_idx*WIDTH +: WIDTH];
      out_sel <= gnt_idx;
    end else if (load) out_valid <= 1'b0;
  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_ready));
  assert property (@(posedge clk) disable iff (!rst_n)
    ARB_MODE == ARB_RR || force_en || !load || in_ready == (in_valid & (~in_valid + 1'b1)));
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: vector table, directed corner sequences and randomized model check of rr_arb_mux
module tb_rr_arb_mux;
`ifdef RR_ARB_MUX_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [3:0] v4, rdy4;
  logic [127:0] d4;
  logic fe4, or4, ov4;
  logic [1:0] fs4, os4;
  logic [31:0] od4;
  logic [2:0] v3 = '0, rdy3;
  logic [95:0] d3 = {32'h2000_0002, 32'h2000_0001, 32'h2000_0000};
  logic fe3 = 1'b0, or3 = 1'b1, ov3;
  logic [1:0] fs3 = '0, os3;
  logic [31:0] od3;
  rr_arb_mux #(.WIDTH(32), .NUM_IN(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_data(d4), .in_ready(rdy4),
    .force_en(fe4), .force_sel(fs4), .out_valid(ov4), .out_data(od4),
    .out_sel(os4), .out_ready(or4)
  );
  rr_arb_mux #(.WIDTH(32), .NUM_IN(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_data(d3), .in_ready(rdy3),
    .force_en(fe3), .force_sel(fs3), .out_valid(ov3), .out_data(od3),
    .out_sel(os3), .out_ready(or3)
  );
  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ov", 32'(ov4), 0);
    chk("rst_rdy", 32'(rdy4), 0);
    edge1();
    rst_n = 1'b1;
  endtask
  typedef struct {
    logic [3:0] v;
    logic fe;
    logic [1:0] fs;
    logic ordy;
    logic [3:0] rdy;
    logic ov;
    logic [1:0] sel;
  } vec_t;
  vec_t tbl[16];
  int m_ptr, m_sel, g;
  bit m_ov, ld;
  logic [31:0] m_data;
  initial begin
    v4 = 4'hF; fe4 = 0; fs4 = 0; or4 = 1;
    for (int i = 0; i < 4; i++) d4[i*32 +: 32] = 32'h1000_0000 + i;
    edge1();
    chk("reset_ov", 32'(ov4), 0);
    chk("reset_data", od4, 0);
    chk("reset_sel", 32'(os4), 0);
    chk("reset_rdy", 32'(rdy4), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tbl[k] = '{4'hF, 0, 0, 1, 4'(1 << (FIXED ? 0 : k % 4)), 1, 2'(FIXED ? 0 : k % 4)};
    end
    tbl[8]  = '{4'hF, 1, 2, 1, 4'b0100, 1, 2};
    tbl[9]  = '{4'h7, 1, 3, 1, 4'b0000, 0, 2};
    tbl[10] = '{4'hF, 0, 0, 1, 4'b0001, 1, 0};
    tbl[11] = '{4'h0, 0, 0, 0, 4'b0000, 1, 0};
    tbl[12] = '{4'h8, 0, 0, 0, 4'b0000, 1, 0};
    tbl[13] = '{4'h8, 0, 0, 1, 4'b1000, 1, 3};
    tbl[14] = '{4'h6, 0, 0, 1, 4'b0010, 1, 1};
    tbl[15] = '{4'h3, 0, 0, 1, 4'b0001, 1, 0};
    for (int k = 0; k < 16; k++) begin
      v4 = tbl[k].v; fe4 = tbl[k].fe; fs4 = tbl[k].fs; or4 = tbl[k].ordy;
      #1;
      chk($sformatf("tbl%0d_rdy", k), 32'(rdy4), 32'(tbl[k].rdy));
      edge1();
      chk($sformatf("tbl%0d_ov", k), 32'(ov4), 32'(tbl[k].ov));
      chk($sformatf("tbl%0d_sel", k), 32'(os4), 32'(tbl[k].sel));
      chk($sformatf("tbl%0d_data", k), od4, 32'h1000_0000 + 32'(tbl[k].sel));
    end
    // backpressure: hold a captured ch1 word, then drain and refill together
    v4 = 4'hF; fe4 = 0; or4 = 1;
    do_reset();
    d4[32 +: 32] = 32'h8000_007F;
    v4 = 4'b0010;
    #1 chk("bp_first_rdy", 32'(rdy4), 32'b0010);
    edge1();
    chk("bp_first_data", od4, 32'h8000_007F);
    v4 = 4'hF; or4 = 0;
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_hold_rdy", 32'(rdy4), 0);
      edge1();
      chk("bp_hold_data", od4, 32'h8000_007F);
      chk("bp_hold_sel", 32'(os4), 1);
      chk("bp_hold_ov", 32'(ov4), 1);
    end
    or4 = 1;
    #1 chk("bp_refill_rdy", 32'(rdy4), FIXED ? 32'b0001 : 32'b0100);
    edge1();
    chk("bp_refill_sel", 32'(os4), FIXED ? 0 : 2);
    chk("bp_refill_ov", 32'(ov4), 1);
    // async reset between edges while holding a word
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ov", 32'(ov4), 0);
    chk("arst_data", od4, 0);
    chk("arst_sel", 32'(os4), 0);
    chk("arst_rdy", 32'(rdy4), 0);
    edge1();
    rst_n = 1'b1;
    // legacy 2:1 select behaviour
    d4[0 +: 32] = 32'h0000_0043;
    v4 = 4'b0011; fe4 = 1; fs4 = 0; or4 = 1;
    edge1();
    chk("legacy_sel0", od4, 32'h0000_0043);
    fs4 = 1;
    edge1();
    chk("legacy_sel1", od4, 32'h8000_007F);
    fe4 = 0; v4 = 4'hF;
    #1 chk("legacy_ptr_rdy", 32'(rdy4), 32'b0001);
    edge1();
    chk("legacy_ptr_sel", 32'(os4), 0);
    // three-channel instance: out-of-range and idle forced channels
    v3 = 3'b111;
    #1 chk("n3_rr_rdy", 32'(rdy3), 32'b001);
    edge1();
    chk("n3_rr_ov", 32'(ov3), 1);
    fe3 = 1; fs3 = 3;
    #1 chk("n3_oor_rdy", 32'(rdy3), 0);
    edge1();
    chk("n3_oor_ov", 32'(ov3), 0);
    fs3 = 1; v3 = 3'b101;
    #1 chk("n3_idle_rdy", 32'(rdy3), 0);
    edge1();
    chk("n3_idle_ov", 32'(ov3), 0);
    fs3 = 2; v3 = 3'b111;
    #1 chk("n3_f2_rdy", 32'(rdy3), 32'b100);
    edge1();
    chk("n3_f2_data", od3, 32'h2000_0002);
    // randomized traffic against a spec-level model
    do_reset();
    m_ptr = 0; m_ov = 0; m_sel = 0; m_data = 0;
    for (int c = 0; c < 600; c++) begin
      v4 = 4'($urandom);
      for (int i = 0; i < 4; i++) d4[i*32 +: 32] = $urandom;
      fe4 = ($urandom_range(3) == 0);
      fs4 = 2'($urandom);
      or4 = 1'($urandom);
      ld = !m_ov || or4;
      g = -1;
      if (fe4) g = v4[fs4] ? int'(fs4) : -1;
      else
        for (int k = 0; k < 4 && g < 0; k++)
          if (v4[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      #1 chk("rnd_rdy", 32'(rdy4), (ld && g >= 0) ? 32'(1 << g) : 0);
      if (ld && g >= 0) begin
        m_ov = 1; m_sel = g; m_data = d4[g*32 +: 32];
        if (!fe4) m_ptr = FIXED ? 0 : (g + 1) % 4;
      end else if (ld) m_ov = 0;
      edge1();
      chk("rnd_ov", 32'(ov4), 32'(m_ov));
      if (m_ov) begin
        chk("rnd_sel", 32'(os4), 32'(m_sel));
        chk("rnd_data", od4, m_data);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-input, W-bit registered arbitrating multiplexer. It generalises the 32-bit 2:1 datapath mux used in the processor datapath.
- Each input is a valid/ready stream. A round-robin arbiter picks one input per cycle, and the chosen word is captured in a one-entry output register with valid/ready.
- A force mode reproduces plain select-driven mux behaviour (the legacy "op" select) for datapath use, e.g. ALU-source and writeback muxes shared by several producers.

Parameters:
- WIDTH, 32, data width per channel.
- NUM_IN, 4, number of input channels (>=2).
- SEL_W, $clog2(NUM_IN), width of select/index fields (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  NUM_IN  per-channel data valid
- in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  output  NUM_IN  per-channel accept; at most one bit high per cycle
- force_en  input  1  1 = only channel force_sel is eligible (select-mux mode)
- force_sel  input  SEL_W  channel index used when force_en=1
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  registered selected word
- out_sel  output  SEL_W  index of the channel that supplied out_data
- out_ready  input  1  downstream accepts out_data this cycle

Behaviour:
- Reset (async on rst_n low, released synchronously to clk): out_valid=0, out_data=0, out_sel=0, rr_ptr=0.
- load = !out_valid || out_ready. No input is accepted while load=0, and all in_ready bits are 0.
- Round-robin grant (force_en=0): g = first i with in_valid[i]=1, searching cyclically from rr_ptr (rr_ptr, rr_ptr+1, ... wrapping at NUM_IN).
- Force grant (force_en=1): g = force_sel if in_valid[force_sel]=1. If force_sel >= NUM_IN, or that channel is not valid, there is no grant.
- in_ready[g] = load && grant exists. in_ready is combinational from in_valid, force_*, out_valid, out_ready and rr_ptr.
- Transfer on channel i = in_valid[i] && in_ready[i].
- On transfer: out_data <= in_data[g], out_sel <= g, out_valid <= 1.
- rr_ptr <= (g==NUM_IN-1) ? 0 : g+1 only on a round-robin transfer. A force-mode transfer leaves rr_ptr unchanged.
- On load with no grant: out_valid <= 0 if out_ready was 1 (word drained). Otherwise the register holds.
- When out_valid=1 and out_ready=0, out_data and out_sel are stable until accepted.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word/cycle when out_ready is held high.
- Fairness: with all inputs continuously valid, the grant sequence is 0,1,...,NUM_IN-1,0,...
- Simultaneous drain and fill: a word is drained and a new word loaded in the same cycle with no bubble.
- Reset asserted mid-transfer: the word is discarded, outputs return to reset values immediately, and no in_ready is high during reset.

Optional Feature:
- Macro: RR_ARB_MUX_FIXED_PRIO_EN.
- Defined: arbitration is fixed priority (lowest index wins). rr_ptr is removed and held logically at 0. Force mode is unchanged.
- Undefined: round-robin as above.

Decomposition:
- Shared package mux_pkg holds:
  - the clog2-based SEL_W helper function;
  - a localparam for the default datapath width (32);
  - an enum for arbitration mode (ARB_RR, ARB_FIXED) reported in a debug/assert context.
- One natural sub-module: rr_picker. It is combinational and takes request vector, start pointer, and force_en/force_sel, and returns grant-valid plus a one-hot and binary grant. rr_arb_mux instantiates it and owns all registers.

Test Plan:
- Reset: rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0000. Release, out_ready=1 -> first grant is channel 0.
- Fairness: NUM_IN=4, all in_valid=1, in_data[i]=32'h1000_000i, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 and one in_ready per cycle.
- Backpressure: out_ready=0 after the first capture of ch1 word 32'h8000_007F -> out_data held for 5 cycles, in_ready=0000. out_ready=1 -> same-cycle drain/refill, next grant ch2.
- Force mode (legacy 2:1 check): NUM_IN=2, in_data0=32'h0000_0043, in_data1=32'h8000_007F, force_en=1, force_sel=0 -> out_data=32'h0000_0043. Then force_sel=1 -> 32'h8000_007F. Verify rr_ptr is unchanged on return to force_en=0.
- Force to an invalid or out-of-range channel: NUM_IN=3, force_sel=3 (or a channel with in_valid=0), out_ready=1 -> no grant, out_valid falls to 0 after drain.
- Async reset mid-stream: pull rst_n low between clk edges while out_valid=1 -> out_valid=0 immediately. Repeat with RR_ARB_MUX_FIXED_PRIO_EN defined, all valid -> channel 0 wins every cycle.
